// File: rtl/seq_divider16.sv
// seq_divider16: 32/16 unsigned restoring divider, one quotient bit per clock (16-clock latency).
// Optional early-exit error checking is enabled by defining DIV_ERR_CHECK_EN.
module seq_divider16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        ovf
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | one restoring step per clock, 16 steps (or 1 cycle on an error exit)
  // DONE  | results valid, done pulses; start here chains straight into RUN
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [15:0] prem_q;
  logic [15:0] dlo_q;
  logic [15:0] dvs_q;
  logic        err_zero_q;
  logic        err_ovf_q;

  logic [16:0] trial;
  logic [16:0] diff;
  logic        fits;
  logic [15:0] prem_d;
  logic [15:0] dlo_d;
  logic        err_zero_d;
  logic        err_ovf_d;

`ifdef DIV_ERR_CHECK_EN
  assign err_zero_d = (divisor == 16'd0);
  assign err_ovf_d  = (divisor != 16'd0) && (dividend[31:16] >= divisor);
`else
  assign err_zero_d = 1'b0;
  assign err_ovf_d  = 1'b0;
`endif

  // dlo_q shifts dividend bits out of the top while quotient bits enter at the bottom
  always_comb begin
    trial  = {prem_q, dlo_q[15]};
    diff   = trial - {1'b0, dvs_q};
    fits   = (trial >= {1'b0, dvs_q});
    prem_d = fits ? diff[15:0] : trial[15:0];
    dlo_d  = {dlo_q[14:0], fits};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      prem_q     <= 16'd0;
      dlo_q      <= 16'd0;
      dvs_q      <= 16'd0;
      err_zero_q <= 1'b0;
      err_ovf_q  <= 1'b0;
      quotient   <= 16'd0;
      remainder  <= 16'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            dvs_q      <= divisor;
            prem_q     <= dividend[31:16];
            dlo_q      <= dividend[15:0];
            cnt_q      <= 5'd0;
            err_zero_q <= err_zero_d;
            err_ovf_q  <= err_ovf_d;
            busy       <= 1'b1;
            state_q    <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (err_zero_q || err_ovf_q) begin
            quotient  <= 16'hFFFF;
            remainder <= 16'h0000;
            div_zero  <= err_zero_q;
            ovf       <= err_ovf_q;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_q   <= DONE;
          end else begin
            prem_q <= prem_d;
            dlo_q  <= dlo_d;
            cnt_q  <= cnt_q + 5'd1;
            if (cnt_q == 5'd15) begin
              quotient  <= dlo_d;
              remainder <= prem_d;
              div_zero  <= 1'b0;
              ovf       <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state_q   <= DONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_divider16.md
SEQ_DIVIDER16 -- requirements
Module: seq_divider16

Interface
REQ-001 SHALL have no parameters; widths are fixed (32-bit dividend, 16-bit divisor, quotient and remainder).
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request a division; sampled on clk rising edge.
REQ-005 dividend  input  32  unsigned dividend; captured when start is accepted.
REQ-006 divisor  input  16  unsigned divisor; captured when start is accepted.
REQ-007 quotient  output  16  unsigned quotient, registered.
REQ-008 remainder  output  16  unsigned remainder, registered.
REQ-009 busy  output  1  high while a division is in progress.
REQ-010 done  output  1  single-cycle pulse when results are valid.
REQ-011 div_zero  output  1  divisor was zero; valid with done.
REQ-012 ovf  output  1  quotient does not fit in 16 bits; valid with done.

Function
REQ-013 SHALL implement the 16x16 multiplier's inverse: for valid operands, dividend = quotient*divisor + remainder, with remainder < divisor.
REQ-014 SHALL use a three-state FSM: IDLE, RUN, DONE.
REQ-015 start SHALL be accepted only in IDLE or DONE; it is ignored in RUN.
REQ-016 On accept: latch operands, clear the 5-bit iteration counter, go to RUN, and set busy=1 from the next cycle.
REQ-017 RUN SHALL perform one restoring step per cycle, MSB first, with a 17-bit partial remainder: shift in the next dividend bit, subtract divisor if the result is >= 0, and set the quotient bit.
REQ-018 After exactly 16 RUN cycles, go to DONE; done=1 and busy=0 for that one cycle, and quotient/remainder are valid.
REQ-019 Latency SHALL be 16 clocks, from the start-accept edge to the edge that raises done.
REQ-020 DONE SHALL go to IDLE next cycle unless start=1, in which case it goes to RUN (back-to-back operations; done still pulses for exactly one cycle).
REQ-021 quotient, remainder, div_zero and ovf SHALL hold their values until the next DONE entry; they change only at DONE entry.
REQ-022 busy and done SHALL never be high simultaneously.
REQ-023 Operand inputs SHALL be don't-care except on the accept edge.

Reset
REQ-024 rst_n low SHALL immediately force IDLE and the following outputs: quotient=0, remainder=0, busy=0, done=0, div_zero=0, ovf=0, counter=0.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-026 The first start after reset release SHALL be honoured on the first rising edge where rst_n=1.

Configuration
REQ-027 Macro DIV_ERR_CHECK_EN.
- Defined: on accept, the block checks for divisor==0 (div_zero=1) or dividend[31:16] >= divisor (ovf=1; div_zero takes priority).
- On either condition: go straight to DONE next edge (latency 1), with quotient=16'hFFFF and remainder=16'h0000.
REQ-028 Without DIV_ERR_CHECK_EN: div_zero and ovf are tied 0; every operation runs 16 iterations; results for invalid operands are the raw iteration outputs.

Verification
REQ-029 dividend=32'h0000_0064, divisor=16'h0007, start pulse -> done 16 clocks later, quotient=16'h000E, remainder=16'h0002, busy high for 16 cycles.
REQ-030 dividend=32'hFFFE_0001, divisor=16'hFFFF -> quotient=16'hFFFF, remainder=16'h0000 (inverse of 16'hFFFF*16'hFFFF).
REQ-031 DIV_ERR_CHECK_EN defined:
- divisor=0 -> done 1 clock later, div_zero=1, ovf=0, quotient=16'hFFFF.
- dividend=32'h0001_0000, divisor=16'h0001 -> ovf=1.
REQ-032 start held high through RUN with different operands -> ignored; the result is for the first operands; the second operation starts from DONE, and done pulses once per operation.
REQ-033 rst_n pulsed low at RUN cycle 8 -> all outputs 0 asynchronously, no done; a new start afterwards completes correctly.
REQ-034 Randomized: 10k random operand pairs with dividend[31:16] < divisor != 0 -> quotient*divisor + remainder == dividend and remainder < divisor.
